// File: rtl/data_sram_ctrl.sv
// Data-memory access sequencer between EX/MEM and a req/addr_ok/data_ok SRAM bus; one access outstanding.
// Latency: request on the bus the cycle after accept; response valid the cycle after data_ok (3 cycles minimum on a zero-wait bus).
// Backpressure: ex_req_ready only in IDLE; the response is held until mem_resp_ready, and wb_ex drops it.
//
// Ports:
//   clk, reset            - clock, async active-high reset
//   wb_ex                 - writeback exception flush
//   ex_req_*              - access from EX (valid/ready handshake)
//   data_sram_*           - SRAM-like bus (req/addr_ok address phase, data_ok/rdata data phase)
//   mem_resp_*            - buffered response to MEM (valid/ready handshake)
//   busy                  - a transaction is in progress
module data_sram_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex,
    input  logic        ex_req_valid,
    input  logic        ex_req_wr,
    input  logic [1:0]  ex_req_size,
    input  logic [31:0] ex_req_addr,
    input  logic [3:0]  ex_req_wstrb,
    input  logic [31:0] ex_req_wdata,
    output logic        ex_req_ready,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        mem_resp_valid,
    output logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        discard_q, discard_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic accept;
    logic capture;

    assign ex_req_ready = (state_q == IDLE) & ~wb_ex;
    assign accept       = ex_req_valid & ex_req_ready;

    // Only a response that survived every flush is buffered for MEM.
    assign capture = (state_q == WAIT) & data_sram_data_ok & ~discard_q & ~wb_ex;

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = REQ;
                    discard_d = 1'b0;
                end
            end
            REQ: begin
                // The request cannot be withdrawn; a flush only marks the response as unwanted.
                if (wb_ex) discard_d = 1'b1;
                if (data_sram_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (wb_ex) discard_d = 1'b1;
                if (data_sram_data_ok) begin
                    if (discard_q || wb_ex) begin
                        state_d   = IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Flush wins over consumption: the response is dropped either way.
                if (wb_ex || mem_resp_ready) state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wstrb_q   <= 4'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (accept) begin
                wr_q    <= ex_req_wr;
                size_q  <= ex_req_size;
                addr_q  <= ex_req_addr;
                // Loads never carry byte enables onto the bus.
                wstrb_q <= ex_req_wr ? ex_req_wstrb : 4'd0;
                wdata_q <= ex_req_wdata;
            end
            if (capture) rdata_q <= data_sram_rdata;
        end
    end

    // Payload is driven straight from the latches, so it is stable for the whole address phase.
    assign data_sram_req   = (state_q == REQ);
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_wdata = wdata_q;

    assign mem_resp_valid  = (state_q == HOLD);
    assign mem_resp_rdata  = rdata_q;
    assign busy            = (state_q != IDLE);

endmodule
